uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL take parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL take parameter ACK_TIMEOUT, default 16, cycles to wait for TX_STATUS to fall after a launch.
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high; clears all state.
REQ-005 SHALL have port wr_en, input, 1, CPU store to the UART TX data address this cycle.
REQ-006 SHALL have port wr_data, input, 8, byte to transmit.
REQ-007 SHALL have port clr_ovf, input, 1, clears the overflow flag.
REQ-008 SHALL have port TX_STATUS, input, 1, 1 = transmitter idle and able to accept a byte.
REQ-009 SHALL have port UART_TXD, output, 8, byte presented to the transmitter.
REQ-010 SHALL have port TX_EN, output, 1, one-cycle launch strobe.
REQ-011 SHALL have port full, output, 1, FIFO holds DEPTH entries.
REQ-012 SHALL have port empty, output, 1, FIFO holds 0 entries.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, occupancy.
REQ-014 SHALL have port busy, output, 1, FSM not in IDLE.
REQ-015 SHALL have port ovf, output, 1, sticky flag: a write was dropped.

Function
REQ-016 SHALL buffer bytes in a circular FIFO with wrapping read and write pointers. count SHALL change by +1 for a write, -1 for a pop, and 0 when both occur in the same cycle.
REQ-017 SHALL accept a write when wr_en=1 and (full=0, or a pop occurs in the same cycle).
REQ-018 SHALL drop a write when wr_en=1, full=1 and no pop occurs. In that case it SHALL set ovf=1 and leave the FIFO contents unchanged.
REQ-019 SHALL clear ovf on clr_ovf=1. If clr_ovf=1 and a new drop occur in the same cycle, ovf SHALL be set (set wins).
REQ-020 SHALL run a four-state FSM: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
REQ-021 IDLE -> LAUNCH when empty=0 and TX_STATUS=1. The FIFO head SHALL be popped into a UART_TXD holding register in that transition cycle.
REQ-022 In LAUNCH, TX_EN SHALL be 1 for exactly one cycle, with UART_TXD stable. The FSM SHALL then go to WAIT_ACK unconditionally.
REQ-023 In WAIT_ACK, a cycle counter SHALL run. The FSM SHALL go to WAIT_DONE when TX_STATUS=0, or after ACK_TIMEOUT cycles if TX_STATUS stays 1 (fast or lost acknowledge).
REQ-024 In WAIT_DONE, the FSM SHALL go to IDLE when TX_STATUS=1.
REQ-025 UART_TXD SHALL hold the last launched byte until the next pop.
REQ-026 TX_EN SHALL be 0 in every state except LAUNCH.
REQ-027 Minimum spacing between TX_EN pulses SHALL be 4 cycles. Latency from a write into an empty FIFO with the FSM in IDLE and TX_STATUS=1 to TX_EN=1 SHALL be 2 cycles.
REQ-028 full, empty and count SHALL be registered, consistent with each other, and valid every cycle.

Reset
REQ-029 On reset=1, asynchronously: pointers=0, count=0, empty=1, full=0, ovf=0, FSM=IDLE, TX_EN=0, UART_TXD=8'h00, busy=0, timeout counter=0.
REQ-030 Reset asserted mid-transmission SHALL discard all buffered bytes. No TX_EN SHALL occur until at least 2 cycles after reset deasserts.

Verification
REQ-031 Reset, then with TX_STATUS=1 write 8'hA5 -> TX_EN pulse 2 cycles later with UART_TXD=8'hA5, then busy=1 until TX_STATUS falls and rises again.
REQ-032 Hold TX_STATUS=0 and write 5 bytes 01..05 with DEPTH=4 -> full=1, count=4, ovf=1. Then release TX_STATUS -> bytes 01..04 are sent in order and 05 is never sent.
REQ-033 With full=1, assert a write in the same cycle as the IDLE->LAUNCH pop -> write accepted, count stays 4, ovf stays 0.
REQ-034 Hold TX_STATUS=1 permanently after a launch -> WAIT_ACK exits after 16 cycles, and the next byte launches with spacing of at least 4 cycles.
REQ-035 Assert reset during WAIT_DONE with 3 bytes queued -> immediately count=0, empty=1, TX_EN=0, UART_TXD=00. No TX_EN occurs after release until a new write.
REQ-036 Assert clr_ovf and an overflowing write in the same cycle -> ovf=1 afterwards.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Buffers CPU bytes in a small circular FIFO and hands them to a UART
// transmitter one at a time. It uses a launch / acknowledge / done handshake
// on TX_STATUS. A watchdog in WAIT_ACK covers an acknowledge that is too fast
// to see, or one that never arrives.

module uart_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       clr_ovf,
  input  logic                       TX_STATUS,
  output logic [7:0]                 UART_TXD,
  output logic                       TX_EN,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;

  // Scheduler state and registered outputs
  state_t        state_r;
  logic [TW-1:0] tout_r;
  logic [7:0]    txd_r;
  logic          tx_en_r;
  logic          busy_r;

  // Per-cycle FIFO events
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [CW-1:0] count_next_s;

  // Decide this cycle's pop, push and drop.
  // A pop frees a slot in the same cycle, so a write to a full FIFO is
  // still accepted when a pop happens at the same time.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if ((state_r == ST_IDLE) && !empty_r && TX_STATUS) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (wr_en && (!full_r || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (wr_en && full_r && !pop_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Compute the next occupancy. A push and a pop in the same cycle cancel out.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Update FIFO storage, the wrapping pointers, and the registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == CW'(0));
    end
  end

  // Sticky overflow flag. A new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Launch FSM.
  // TX_EN, busy and UART_TXD are registered with each transition, so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      tout_r  <= '0;
      txd_r   <= 8'h00;
      tx_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tout_r <= '0;
          if (pop_s) begin
            txd_r   <= mem_r[rd_ptr_r];
            tx_en_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_LAUNCH;
          end else begin
            tx_en_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          tx_en_r <= 1'b0;
          busy_r  <= 1'b1;
          tout_r  <= '0;
          state_r <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          tx_en_r <= 1'b0;
          busy_r  <= 1'b1;
          // A missing acknowledge must not stall the queue forever.
          if (!TX_STATUS || (tout_r == TW'(ACK_TIMEOUT - 1))) begin
            tout_r  <= '0;
            state_r <= ST_WAIT_DONE;
          end else begin
            tout_r  <= tout_r + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          tx_en_r <= 1'b0;
          tout_r  <= '0;
          if (TX_STATUS) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        default: begin
          tx_en_r <= 1'b0;
          busy_r  <= 1'b0;
          tout_r  <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign UART_TXD = txd_r;
  assign TX_EN    = tx_en_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign busy     = busy_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed testbench for uart_tx_scheduler (DEPTH=4, ACK_TIMEOUT=16).

module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       TX_STATUS = 1'b1;
  logic [7:0] UART_TXD;
  logic       TX_EN;
  logic       full;
  logic       empty;
  logic [2:0] count;
  logic       busy;
  logic       ovf;

  int tests = 0;
  int failed = 0;

  uart_tx_scheduler #(.DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .clr_ovf(clr_ovf), .TX_STATUS(TX_STATUS), .UART_TXD(UART_TXD),
    .TX_EN(TX_EN), .full(full), .empty(empty), .count(count),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (empty !== 1'b1) begin failed++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    tests++; if (TX_EN !== 1'b0) begin failed++; $display("FAIL reset_txen got %b exp 0", TX_EN); end
    tests++; if (UART_TXD !== 8'h00) begin failed++; $display("FAIL reset_txd got %h exp 00", UART_TXD); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    TX_STATUS = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    tests++; if (count !== 3'd1 || empty !== 1'b0 || TX_EN !== 1'b0) begin
      failed++; $display("FAIL single_queued count=%0d empty=%b txen=%b exp 1 0 0", count, empty, TX_EN); end
    tick();
    tests++; if (TX_EN !== 1'b1 || UART_TXD !== 8'hA5) begin
      failed++; $display("FAIL single_launch txen=%b txd=%h exp 1 a5", TX_EN, UART_TXD); end
    tests++; if (busy !== 1'b1 || count !== 3'd0) begin
      failed++; $display("FAIL single_busy busy=%b count=%0d exp 1 0", busy, count); end
    tick();
    tests++; if (TX_EN !== 1'b0 || busy !== 1'b1) begin
      failed++; $display("FAIL single_waitack txen=%b busy=%b exp 0 1", TX_EN, busy); end
    TX_STATUS = 1'b0;
    tick(); tick();
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL single_waitdone busy=%b exp 1", busy); end
    TX_STATUS = 1'b1;
    tick();
    tests++; if (busy !== 1'b0 || UART_TXD !== 8'hA5) begin
      failed++; $display("FAIL single_idle busy=%b txd=%h exp 0 a5", busy, UART_TXD); end
  endtask

  task automatic test_overflow();
    logic [7:0] got [8];
    int n = 0;
    int lo = 0;
    TX_STATUS = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    tests++; if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b1) begin
      failed++; $display("FAIL ovf_fill full=%b count=%0d ovf=%b exp 1 4 1", full, count, ovf); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    TX_STATUS = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (TX_EN === 1'b1) begin
        if (n < 8) got[n] = UART_TXD;
        n++;
        TX_STATUS = 1'b0; lo = 2;
      end else if (lo > 0) begin
        lo--;
        if (lo == 0) TX_STATUS = 1'b1;
      end
    end
    tests++; if (n !== 4) begin failed++; $display("FAIL ovf_sent_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (n <= i || got[i] !== 8'(i + 1)) begin
        failed++; $display("FAIL ovf_order[%0d] got %h exp %h", i, (n > i) ? got[i] : 8'hxx, 8'(i + 1)); end
    end
    tests++; if (empty !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL ovf_drained empty=%b busy=%b exp 1 0", empty, busy); end
  endtask

  task automatic test_full_pop();
    logic [7:0] got [8];
    logic [7:0] exp_b [5];
    int n = 0;
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13; exp_b[3] = 8'h14; exp_b[4] = 8'hAA;
    TX_STATUS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = exp_b[i];
      tick();
    end
    tests++; if (full !== 1'b1 || ovf !== 1'b0) begin
      failed++; $display("FAIL fp_full full=%b ovf=%b exp 1 0", full, ovf); end
    TX_STATUS = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    tests++; if (count !== 3'd4 || full !== 1'b1 || ovf !== 1'b0) begin
      failed++; $display("FAIL fp_same_cycle count=%0d full=%b ovf=%b exp 4 1 0", count, full, ovf); end
    tests++; if (TX_EN !== 1'b1 || UART_TXD !== 8'h11) begin
      failed++; $display("FAIL fp_launch txen=%b txd=%h exp 1 11", TX_EN, UART_TXD); end
    got[0] = UART_TXD; n = 1;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (TX_EN === 1'b1) begin
        if (n < 8) got[n] = UART_TXD;
        n++;
      end
    end
    tests++; if (n !== 5) begin failed++; $display("FAIL fp_sent_count got %0d exp 5", n); end
    for (int i = 1; i < 5; i++) begin
      tests++; if (n <= i || got[i] !== exp_b[i]) begin
        failed++; $display("FAIL fp_order[%0d] got %h exp %h", i, (n > i) ? got[i] : 8'hxx, exp_b[i]); end
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int second = -1;
    TX_STATUS = 1'b1;
    wr_en = 1'b1; wr_data = 8'hB1;
    tick();
    wr_data = 8'hB2;
    tick();
    wr_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (TX_EN === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick();
    end
    tests++; if (first !== 0) begin failed++; $display("FAIL to_first_launch got %0d exp 0", first); end
    tests++; if (second - first !== 19) begin
      failed++; $display("FAIL to_spacing got %0d exp 19", second - first); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    TX_STATUS = 1'b1;
    wr_en = 1'b1; wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick();
    wr_data = 8'hC3; TX_STATUS = 1'b0; tick();
    wr_data = 8'hC4; tick();
    wr_en = 1'b0;
    tests++; if (busy !== 1'b1 || count !== 3'd3) begin
      failed++; $display("FAIL rm_before busy=%b count=%0d exp 1 3", busy, count); end
    reset = 1'b1;
    #1;
    tests++; if (count !== 3'd0 || empty !== 1'b1 || TX_EN !== 1'b0 || UART_TXD !== 8'h00 || busy !== 1'b0) begin
      failed++; $display("FAIL rm_async count=%0d empty=%b txen=%b txd=%h busy=%b exp 0 1 0 00 0",
                         count, empty, TX_EN, UART_TXD, busy); end
    TX_STATUS = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (TX_EN === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin failed++; $display("FAIL rm_no_launch got %b exp 0", seen); end
    wr_en = 1'b1; wr_data = 8'hD7; tick();
    wr_en = 1'b0; tick();
    tests++; if (TX_EN !== 1'b1 || UART_TXD !== 8'hD7) begin
      failed++; $display("FAIL rm_relaunch txen=%b txd=%h exp 1 d7", TX_EN, UART_TXD); end
    for (int c = 0; c < 25; c++) tick();
  endtask

  task automatic test_ovf_clr();
    TX_STATUS = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE0 + i);
      tick();
    end
    tests++; if (ovf !== 1'b0 || full !== 1'b1) begin
      failed++; $display("FAIL oc_exact_fill ovf=%b full=%b exp 0 1", ovf, full); end
    clr_ovf = 1'b1; wr_data = 8'hEF;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    tests++; if (ovf !== 1'b1 || count !== 3'd4) begin
      failed++; $display("FAIL oc_set_wins ovf=%b count=%0d exp 1 4", ovf, count); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests++; if (ovf !== 1'b0) begin failed++; $display("FAIL oc_clear got %b exp 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_ovf_clr();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
